cpu_sequencer: RTL

//   Multi-cycle state sequencer for the MIPS datapath. Drives the 3-bit `state` code consumed by control.

---
 rtl/cpu_sequencer_if.sv | 27 ++
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Bundle between the multi-cycle sequencer and the rest of the MIPS core.
// The master side is the sequencer: it samples decode fields and memory
// waitrequest, and drives the state code, control pulses and status.
interface cpu_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic               waitrequest;
    logic [5:0]         opcode;
    logic [5:0]         function_code;
    logic               jump_target_zero;
    logic [2:0]         state;
    logic               ir_load;
    logic               pc_write_enable;
    logic               div_start;
    logic               active;
    logic [COUNT_W-1:0] retired_count;

    modport master (
        input  waitrequest, opcode, function_code, jump_target_zero,
        output state, ir_load, pc_write_enable, div_start, active, retired_count
    );

    modport slave (
        output waitrequest, opcode, function_code, jump_target_zero,
        input  state, ir_load, pc_write_enable, div_start, active, retired_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle state sequencer for the MIPS datapath.
// FETCH -> EXEC -> (MEM | DIVWAIT | HALT | FETCH). Memory states stall on
// waitrequest, DIVWAIT burns the fixed divider latency, and a JR/JALR to
// address 0 parks the core in HALT until reset. The control pulses are
// combinational from the current state and inputs so control sees them in
// the same cycle; they are forced low while reset is asserted.
module cpu_sequencer #(
    parameter int DIV_LATENCY = 33,
    parameter int COUNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
);
    // Counter only needs to hold DIV_LATENCY-1; keep at least one bit.
    localparam int              DIV_W    = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_LATENCY - 1);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_MEM     = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_HALT    = 3'd3;
    localparam logic [2:0] S_DIVWAIT = 3'd4;

    // Loads and stores: LB LH LWL LW LBU LHU LWR, SB SH SW.
    localparam int         NUM_MEM_OPS = 10;
    localparam logic [5:0] MEM_OPS [NUM_MEM_OPS] = '{
        6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd40, 6'd41, 6'd43
    };

    // State is kept as a raw 3-bit code so the unused codes 5-7 stay visible
    // to the recovery path instead of being hidden behind an enum.
    logic [2:0]         state_reg;
    logic [2:0]         state_next;
    logic               active_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [DIV_W-1:0]   div_cnt_next;
    logic [COUNT_W-1:0] retired_reg;

    logic               ir_load_int;
    logic               pc_write_int;
    logic               div_start_int;

    logic [NUM_MEM_OPS-1:0] mem_hit;
    logic                   is_mem;
    logic                   is_special;
    logic                   is_div;
    logic                   is_halt;

    for (genvar gi = 0; gi < NUM_MEM_OPS; gi++) begin : g_mem_op
        assign mem_hit[gi] = (bus.opcode == MEM_OPS[gi]);
    end

    assign is_mem     = |mem_hit;
    assign is_special = (bus.opcode == 6'd0);
    assign is_div     = is_special &&
                        ((bus.function_code == 6'd26) || (bus.function_code == 6'd27));
    assign is_halt    = is_special && bus.jump_target_zero &&
                        ((bus.function_code == 6'd8) || (bus.function_code == 6'd9));

    // State, divide counter, run flag and retire counter; reset clears all asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            active_reg  <= 1'b0;
            div_cnt_reg <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            active_reg  <= (state_next != S_HALT);
            div_cnt_reg <= div_cnt_next;
            if (pc_write_int) begin
                retired_reg <= retired_reg + COUNT_W'(1);
            end
        end
    end

    // Next-state and divide-counter decode.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        case (state_reg)
            S_FETCH: begin
                if (!bus.waitrequest) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_next = S_MEM;
                end else if (is_div) begin
                    state_next   = S_DIVWAIT;
                    div_cnt_next = DIV_LOAD;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (!bus.waitrequest) begin
                    state_next = S_FETCH;
                end
            end
            S_DIVWAIT: begin
                if (div_cnt_reg != '0) begin
                    div_cnt_next = div_cnt_reg - DIV_W'(1);
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Control pulses from the current state and inputs; silent during reset and in HALT.
    always_comb begin
        ir_load_int   = 1'b0;
        pc_write_int  = 1'b0;
        div_start_int = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    ir_load_int = !bus.waitrequest;
                end
                S_EXEC: begin
                    div_start_int = is_div;
                    pc_write_int  = !is_mem && !is_div;
                end
                S_MEM: begin
                    pc_write_int = !bus.waitrequest;
                end
                S_DIVWAIT: begin
                    pc_write_int = (div_cnt_reg == '0);
                end
                default: begin
                    ir_load_int   = 1'b0;
                    pc_write_int  = 1'b0;
                    div_start_int = 1'b0;
                end
            endcase
        end
    end

    assign bus.state           = state_reg;
    assign bus.active          = active_reg;
    assign bus.retired_count   = retired_reg;
    assign bus.ir_load         = ir_load_int;
    assign bus.pc_write_enable = pc_write_int;
    assign bus.div_start       = div_start_int;
endmodule
